fetch_pc_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-issue RISC-V core. It consumes branch/jump targets produced by the PC+offset adder through the redirect interface and drives the instruction-memory request/response channel. It presents fetched instructions to decode over a valid/ready handshake.
- One outstanding memory request at a time; no prediction.

---
 rtl/fetch_pc_unit_pkg.sv | 21 ++
 rtl/fetch_pc_unit_adder.sv | 19 +
 rtl/fetch_pc_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// fetch_pc_unit_pkg : shared widths, reset PC, PC step and fetch state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pc_unit_pkg;

    localparam int unsigned     DATA_WIDTH    = 32;
    localparam logic [31:0]     C_RESET_PC    = 32'h0000_0000;
    localparam int unsigned     C_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_adder.sv
// ============================================================================
// fetch_pc_unit_adder : PC + offset adder, wraps modulo 2^XLEN
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit_adder #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_offset,
    output logic [XLEN-1:0] o_sum
);

    assign o_sum = i_pc + i_offset;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : PC register and single-outstanding instruction fetch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = DATA_WIDTH,
    parameter logic [XLEN-1:0] RESET_PC    = C_RESET_PC,
    parameter int unsigned     INSTR_BYTES = C_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data,
    input  logic            inst_ready,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(INSTR_BYTES);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_inst_fire;

    fetch_pc_unit_adder #(
        .XLEN (XLEN)
    ) u_pc_adder (
        .i_pc     (pc_q),
        .i_offset (C_PC_STEP),
        .o_sum    (w_pc_inc)
    );

    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_req_fire    = req_valid_q & imem_req_ready;
    assign w_inst_fire   = inst_valid_q & inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        inst_pc_d    = inst_pc_q;
        inst_data_d  = inst_data_q;
        misaligned_d = 1'b0;

        case (state_q)
            FETCH_REQ: begin
                if (w_req_fire) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = FETCH_REQ;
                    end else begin
                        inst_pc_d   = pc_q;
                        inst_data_d = imem_rsp_data;
                        state_d     = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (w_inst_fire) begin
                    pc_d    = w_pc_inc;
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        // A redirect overrides whatever the sequencer decided above.
        if (redirect_valid) begin
            pc_d         = w_redirect_pc;
            misaligned_d = |redirect_pc[1:0];
            case (state_q)
                FETCH_REQ: begin
                    if (w_req_fire) begin
                        discard_d = 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    inst_pc_d   = inst_pc_q;
                    inst_data_d = inst_data_q;
                    discard_d   = ~imem_rsp_valid;
                    state_d     = imem_rsp_valid ? FETCH_REQ : FETCH_WAIT;
                end
                FETCH_HOLD: begin
                    state_d = FETCH_REQ;
                end
                default: begin
                    state_d = FETCH_REQ;
                end
            endcase
        end

        req_valid_d  = (state_d == FETCH_REQ);
        inst_valid_d = (state_d == FETCH_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH_REQ;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_pc_q    <= inst_pc_d;
            inst_data_q  <= inst_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_pc        = inst_pc_q;
    assign inst_data      = inst_data_q;
    assign misaligned     = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : directed + random checks of fetch_pc_unit against a
// transaction-level model and a small instruction-memory responder
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    localparam logic [31:0] C_PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready),
        .misaligned     (misaligned)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // values sampled at the falling edge
    logic        s_req_valid, s_inst_valid, s_misal, s_acc, s_xfer;
    logic [31:0] s_addr, s_inst_pc, s_inst_data;

    // reference model: architectural next PC, one outstanding fetch, one held slot
    logic        m_rst, m_out, m_stale, m_held, m_misal;
    logic [31:0] m_pc, m_hpc, m_hdata;

    // memory responder
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    bit          mem_pend = 1'b0;
    bit          mem_spur = 1'b0;
    logic [31:0] mem_addr = '0;

    logic [31:0] req_log[$];
    logic [31:0] xfer_log[$];
    logic [31:0] xfer_dat[$];
    int          xfer_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rst = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_misal = 1'b0;
        m_pc = 32'h0; m_hpc = 32'h0; m_hdata = 32'h0;
    endtask

    task automatic model_update();
        logic req_v;
        if (!rst_n) begin
            model_reset();
        end else begin
            req_v   = !m_rst && !m_out && !m_held;
            m_misal = redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (m_held) begin
                if (inst_ready) begin
                    m_held = 1'b0;
                    if (!redirect_valid) m_pc = m_pc + 32'd4;
                end
            end else if (m_out) begin
                if (imem_rsp_valid) begin
                    m_out = 1'b0;
                    if (!m_stale && !redirect_valid) begin
                        m_held  = 1'b1;
                        m_hpc   = m_pc;
                        m_hdata = imem_rsp_data;
                    end
                    m_stale = 1'b0;
                end else if (redirect_valid) begin
                    m_stale = 1'b1;
                end
            end else if (req_v && imem_req_ready) begin
                m_out   = 1'b1;
                m_stale = redirect_valid;
            end
            if (redirect_valid) begin
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
                m_held = 1'b0;
            end
            m_rst = 1'b0;
        end
    endtask

    task automatic mem_drive();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_addr ^ C_PAT;
                mem_pend       = 1'b0;
            end
        end else if (mem_spur && $urandom_range(0, 7) == 0) begin
            imem_rsp_valid = 1'b1;
        end
    endtask

    task automatic cycle();
        logic exp_req;
        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_addr       = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst_data  = inst_data;
        s_misal      = misaligned;
        exp_req      = !m_rst && !m_out && !m_held;
        chk("req_valid", 32'(s_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", s_addr, m_pc);
        chk("addr_align", 32'(s_addr[1:0]), 32'd0);
        chk("inst_valid", 32'(s_inst_valid), 32'(m_held));
        if (m_held || m_rst) begin
            chk("inst_pc", s_inst_pc, m_rst ? 32'h0 : m_hpc);
            chk("inst_data", s_inst_data, m_rst ? 32'h0 : m_hdata);
        end
        chk("misaligned", 32'(s_misal), 32'(m_misal));
        s_acc  = s_req_valid && imem_req_ready;
        s_xfer = s_inst_valid && inst_ready;
        if (s_acc) req_log.push_back(s_addr);
        if (s_xfer) begin
            xfer_log.push_back(s_inst_pc);
            xfer_dat.push_back(s_inst_data);
            xfer_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_update();
        if (!rst_n) begin
            mem_pend = 1'b0;
        end else if (s_acc) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = s_addr;
        end
        cyc++;
        #1;
        mem_drive();
    endtask

    task automatic clear_logs();
        req_log.delete(); xfer_log.delete(); xfer_dat.delete(); xfer_cyc.delete();
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle(); cycle();
        chk("rst_req_valid", 32'(s_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(s_inst_valid), 32'd0);

        // sequential fetch, then a stalled request at 0x8
        rst_n = 1'b1;
        clear_logs();
        repeat (7) cycle();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_addr", s_addr, 32'h8);
            chk("stall_valid", 32'(s_req_valid), 32'd1);
        end
        imem_req_ready = 1'b1;
        repeat (6) cycle();
        chk("seq_nreq", 32'(req_log.size()), 32'd4);
        chk("seq_nxfer", 32'(xfer_log.size()), 32'd4);
        if (req_log.size() >= 4 && xfer_log.size() >= 4) begin
            chk("seq_req0", req_log[0], 32'h0);
            chk("seq_req1", req_log[1], 32'h4);
            chk("seq_req2", req_log[2], 32'h8);
            chk("seq_req3", req_log[3], 32'hC);
            chk("seq_pc2", xfer_log[2], 32'h8);
            chk("seq_dat0", xfer_dat[0], 32'h0 ^ C_PAT);
            chk("seq_dat2", xfer_dat[2], 32'h8 ^ C_PAT);
            chk("seq_rate", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
        end

        // redirect while waiting for the 0x10 response
        mem_lat = 2;
        clear_logs();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_acc && s_addr == 32'h10) found = 1'b1;
        end
        chk("reach_0x10", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        mem_lat = 1;
        chk("wait_nreq", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) chk("wait_req1", req_log[1], 32'h100);
        chk("wait_nxfer", 32'(xfer_log.size() >= 1), 32'd1);
        if (xfer_log.size() >= 1) chk("wait_xfer0", xfer_log[0], 32'h100);

        // misaligned redirect in HOLD with a same-cycle handshake
        inst_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_inst_valid) found = 1'b1;
        end
        chk("reach_hold", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h203; inst_ready = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("mis_pulse", 32'(s_misal), 32'd1);
        chk("mis_inst_valid", 32'(s_inst_valid), 32'd0);
        chk("mis_req_valid", 32'(s_req_valid), 32'd1);
        chk("mis_addr", s_addr, 32'h200);
        cycle();
        chk("mis_clear", 32'(s_misal), 32'd0);

        // PC wrap past the top of the address space
        clear_logs();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        repeat (12) cycle();
        found = 1'b0;
        for (int i = 0; i + 1 < req_log.size(); i++) begin
            if (!found && req_log[i] == 32'hFFFF_FFFC) begin
                chk("wrap_next", req_log[i+1], 32'h0);
                found = 1'b1;
            end
        end
        chk("wrap_found", 32'(found), 32'd1);

        // reset while a response is outstanding
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_acc) found = 1'b1;
        end
        chk("reach_wait", 32'(found), 32'd1);
        rst_n = 1'b0;
        cycle(); cycle();
        chk("mrst_req_valid", 32'(s_req_valid), 32'd0);
        chk("mrst_inst_valid", 32'(s_inst_valid), 32'd0);
        chk("mrst_inst_pc", s_inst_pc, 32'h0);
        chk("mrst_inst_data", s_inst_data, 32'h0);
        chk("mrst_misal", 32'(s_misal), 32'd0);
        rst_n = 1'b1;
        cycle(); cycle();
        chk("mrst_first_valid", 32'(s_req_valid), 32'd1);
        chk("mrst_first_addr", s_addr, 32'h0);

        // randomized traffic against the model
        mem_spur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            mem_lat        = $urandom_range(1, 3);
            rst_n          = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
